// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Deserialises the asynchronous rx line using the rising edge of the baud
// generator's rx_enbl strobe as the sample tick. Frames are start, DATA_BITS
// data bits (LSB first), an optional parity bit and one stop bit. Each good
// word is handed to the consumer through a valid/ready register. Framing,
// parity and overrun problems are reported as single-cycle pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 rx_enbl,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  // Counter widths follow the oversample ratio and the data bit count.
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Tick count at which the start bit is re-checked (its middle) and at
  // which every later bit is sampled (one full bit period after the middle
  // of the previous bit).
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};

  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};

  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Parity check: the data bits together with the received parity bit must
  // have the polarity selected by PARITY_ODD; returns 1 on mismatch.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic par_bit);
    return (((^data) ^ par_bit) != PAR_ODD);
  endfunction

  // Input conditioning
  logic rx_meta_r;
  logic rxs_r;
  logic enbl_r;

  // Frame state
  state_t                 state_r;
  logic [TW-1:0]          tick_cnt_r;
  logic [BW-1:0]          bit_cnt_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_err_r;
  logic                   busy_r;
  logic                   frame_err_r;
  logic                   parity_err_r;

  // Output register
  logic [DATA_BITS-1:0]   rx_data_r;
  logic                   rx_valid_r;
  logic                   overrun_r;

  // Decoded strobes
  logic tick_s;
  logic bit_end_s;
  logic stop_done_s;
  logic deliver_s;

  // Two-flop synchronizer for the asynchronous line (idle level is high) and
  // the previous value of the baud strobe for rising-edge detection.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
      enbl_r    <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
      enbl_r    <= rx_enbl;
    end
  end

  // Sample tick and the stop-bit completion strobe that feeds the output register.
  always_comb begin
    tick_s      = rx_enbl & ~enbl_r;
    bit_end_s   = tick_s & (tick_cnt_r == TICK_END);
    stop_done_s = 1'b0;
    if (state_r == ST_STOP) begin
      stop_done_s = bit_end_s;
    end else begin
      stop_done_s = 1'b0;
    end
    deliver_s = stop_done_s & rxs_r & ~par_err_r;
  end

  // Receive FSM: start detection, bit sampling, parity/stop checking and the
  // busy and error-pulse outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= TICK_ZERO;
      bit_cnt_r    <= BIT_ZERO;
      shift_r      <= {DATA_BITS{1'b0}};
      par_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rxs_r) begin
            state_r    <= ST_START;
            tick_cnt_r <= TICK_ZERO;
            par_err_r  <= 1'b0;
            busy_r     <= 1'b1;
          end
        end

        ST_START: begin
          if (tick_s) begin
            if (tick_cnt_r == TICK_MID) begin
              tick_cnt_r <= TICK_ZERO;
              bit_cnt_r  <= BIT_ZERO;
              if (!rxs_r) begin
                state_r <= ST_DATA;
              end else begin
                // Line went back high before mid-start: treat as a glitch.
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
        end

        ST_DATA: begin
          if (tick_s) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= TICK_ZERO;
              // Shift in from the top so the first bit ends up at bit 0.
              shift_r    <= {rxs_r, shift_r[DATA_BITS-1:1]};
              bit_cnt_r  <= bit_cnt_r + BIT_ONE;
              if (bit_cnt_r == BIT_LAST) begin
                state_r <= PAR_EN ? ST_PARITY : ST_STOP;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
        end

        ST_PARITY: begin
          if (tick_s) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= TICK_ZERO;
              par_err_r  <= parity_mismatch(shift_r, rxs_r);
              state_r    <= ST_STOP;
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
        end

        ST_STOP: begin
          if (tick_s) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= TICK_ZERO;
              if (rxs_r) begin
                // Good stop bit: the word is either delivered by the output
                // register or dropped here because of a parity error.
                parity_err_r <= par_err_r;
                state_r      <= ST_IDLE;
                busy_r       <= 1'b0;
              end else begin
                // Low stop bit wins over any parity result.
                frame_err_r <= 1'b1;
                state_r     <= ST_BREAK;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
          end
        end

        ST_BREAK: begin
          // Hold off new start detection until the line has returned high.
          if (rxs_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output word register: consume on valid&ready, load on delivery, and
  // flag an overrun when a delivery finds an unconsumed word.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rx_data_r  <= {DATA_BITS{1'b0}};
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (deliver_s) begin
        if (rx_valid_r && !rx_ready) begin
          // Old word kept, new word lost.
          overrun_r <= 1'b1;
        end else begin
          // Either empty, or the old word is consumed in this same cycle.
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign rx_busy     = busy_r;
  assign frame_err   = frame_err_r;
  assign parity_err  = parity_err_r;
  assign overrun_err = overrun_r;

endmodule
